// File: rtl/cq_doorbell_axil_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cq_doorbell_axil_slave                                                      |
// | AXI4-Lite register slave for SQ tail / CQ head doorbells and CQ interrupt.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cq_doorbell_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          QUEUE_DEPTH        = 16,
  parameter logic [31:0] ID_VALUE           = 32'h4351_0200,
  localparam int         QW                 = $clog2(QUEUE_DEPTH)
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [QW-1:0]                   cq_tail_in,
  output logic [QW-1:0]                   cq_head_out,
  output logic                            cq_head_upd,
  output logic [QW-1:0]                   sq_tail_out,
  output logic                            sq_tail_upd,
  output logic                            irq
);

  localparam logic [2:0] C_IDX_SQ_TAIL = 3'd0;
  localparam logic [2:0] C_IDX_CQ_HEAD = 3'd1;
  localparam logic [2:0] C_IDX_CQ_TAIL = 3'd2;
  localparam logic [2:0] C_IDX_STATUS  = 3'd3;
  localparam logic [2:0] C_IDX_CTRL    = 3'd4;
  localparam logic [2:0] C_IDX_ID      = 3'd5;
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  // write channel state
  logic          r_awready;
  logic          r_wready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_aw_have;
  logic          r_w_have;
  logic [2:0]    r_aw_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;

  // register file
  logic [QW-1:0] r_sq_tail;
  logic [QW-1:0] r_cq_head;
  logic          r_sq_upd;
  logic          r_cq_upd;
  logic          r_irq_en;
  logic          r_err;
  logic          r_irq;

  // read channel state
  logic          r_arready;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic          w_aw_have_nx;
  logic          w_w_have_nx;
  logic          w_bvalid_nx;
  logic          w_rvalid_nx;
  logic          w_is_doorbell;
  logic          w_db_bad;
  logic          w_wr_err;
  logic          w_ctrl_wr;
  logic [QW-1:0] w_pending;
  logic [8:0]    w_pending9;
  logic [31:0]   w_status;
  logic [2:0]    w_ar_idx;
  logic [31:0]   w_rd_data;
  logic [1:0]    w_rd_resp;
  logic          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_commit = r_aw_have & r_w_have;

  assign w_aw_have_nx = (r_aw_have | w_aw_hs) & ~w_commit;
  assign w_w_have_nx  = (r_w_have | w_w_hs) & ~w_commit;
  assign w_bvalid_nx  = w_commit | (r_bvalid & ~S_AXI_BREADY);
  assign w_rvalid_nx  = w_ar_hs | (r_rvalid & ~S_AXI_RREADY);

  // Doorbells must be full-word writes of an in-range queue index.
  assign w_is_doorbell = (r_aw_idx == C_IDX_SQ_TAIL) || (r_aw_idx == C_IDX_CQ_HEAD);
  assign w_db_bad      = (r_wstrb != 4'hF) || ((r_wdata >> QW) != 32'd0);
  assign w_wr_err      = w_is_doorbell ? w_db_bad : (r_aw_idx != C_IDX_CTRL);
  assign w_ctrl_wr     = w_commit && (r_aw_idx == C_IDX_CTRL) && r_wstrb[0];

  assign w_pending  = cq_tail_in - r_cq_head;
  assign w_pending9 = 9'(w_pending);
  assign w_status   = {r_err, 22'd0, w_pending9};

  assign w_ar_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = C_RESP_OKAY;
    case (w_ar_idx)
      C_IDX_SQ_TAIL: w_rd_data = 32'(r_sq_tail);
      C_IDX_CQ_HEAD: w_rd_data = 32'(r_cq_head);
      C_IDX_CQ_TAIL: w_rd_data = 32'(cq_tail_in);
      C_IDX_STATUS:  w_rd_data = w_status;
      C_IDX_CTRL:    w_rd_data = {30'd0, r_err, r_irq_en};
      C_IDX_ID:      w_rd_data = ID_VALUE;
      default:       w_rd_resp = C_RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= C_RESP_OKAY;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_aw_idx  <= 3'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_sq_tail <= '0;
      r_cq_head <= '0;
      r_sq_upd  <= 1'b0;
      r_cq_upd  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= C_RESP_OKAY;
    end else begin
      // Ready flags are registered from next-state so they never lead the latch.
      r_awready <= ~w_aw_have_nx & ~w_bvalid_nx;
      r_wready  <= ~w_w_have_nx & ~w_bvalid_nx;
      r_aw_have <= w_aw_have_nx;
      r_w_have  <= w_w_have_nx;
      r_bvalid  <= w_bvalid_nx;
      if (w_aw_hs) begin
        r_aw_idx <= S_AXI_AWADDR[4:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end

      r_sq_upd <= 1'b0;
      r_cq_upd <= 1'b0;
      if (w_commit) begin
        r_bresp <= w_wr_err ? C_RESP_SLVERR : C_RESP_OKAY;
        if (!w_wr_err && r_aw_idx == C_IDX_SQ_TAIL) begin
          r_sq_tail <= r_wdata[QW-1:0];
          r_sq_upd  <= 1'b1;
        end
        if (!w_wr_err && r_aw_idx == C_IDX_CQ_HEAD) begin
          r_cq_head <= r_wdata[QW-1:0];
          r_cq_upd  <= 1'b1;
        end
      end
      if (w_ctrl_wr) begin
        r_irq_en <= r_wdata[0];
      end
      // A new error takes priority over a same-cycle clear.
      if (w_commit && w_wr_err) begin
        r_err <= 1'b1;
      end else if (w_ctrl_wr && r_wdata[1]) begin
        r_err <= 1'b0;
      end
      r_irq <= r_irq_en & (w_pending != '0);

      r_arready <= ~w_rvalid_nx;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign sq_tail_out   = r_sq_tail;
  assign sq_tail_upd   = r_sq_upd;
  assign cq_head_out   = r_cq_head;
  assign cq_head_upd   = r_cq_upd;
  assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cq_doorbell_axil_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cq_doorbell_axil_slave                                                   |
// | Directed AXI4-Lite bench with a register-level model and per-cycle checker. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cq_doorbell_axil_slave;

  localparam int          DEPTH = 16;
  localparam int          QW    = 4;
  localparam logic [31:0] ID    = 32'h4351_0200;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [4:0]    S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [4:0]    S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [QW-1:0] cq_tail_in;
  logic [QW-1:0] cq_head_out;
  logic          cq_head_upd;
  logic [QW-1:0] sq_tail_out;
  logic          sq_tail_upd;
  logic          irq;

  cq_doorbell_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .QUEUE_DEPTH(DEPTH),
    .ID_VALUE(ID)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cq_tail_in(cq_tail_in), .cq_head_out(cq_head_out), .cq_head_upd(cq_head_upd),
    .sq_tail_out(sq_tail_out), .sq_tail_upd(sq_tail_upd), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  // Register-level model: state as it must appear after the commit edge.
  int m_sq, m_cq, m_irq_en, m_err, m_sq_upd, m_cq_upd;
  int p_irq_en, p_head;
  bit mon_en = 0;
  int tail_e;
  bit rst_e;
  int exp_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pending_of(input int tail, input int head);
    return (tail - head + DEPTH) % DEPTH;
  endfunction

  task automatic model_zero();
    m_sq = 0; m_cq = 0; m_irq_en = 0; m_err = 0; m_sq_upd = 0; m_cq_upd = 0;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    idx  = int'(addr) / 4;
    resp = 2'b00;
    if (idx == 0 || idx == 1) begin
      if (strb != 4'hF || data >= DEPTH) begin
        m_err = 1;
        resp  = 2'b10;
      end else if (idx == 0) begin
        m_sq = int'(data); m_sq_upd = 1;
      end else begin
        m_cq = int'(data); m_cq_upd = 1;
      end
    end else if (idx == 4) begin
      if (strb[0]) begin
        m_irq_en = int'(data[0]);
        if (data[1]) m_err = 0;
      end
    end else begin
      m_err = 1;
      resp  = 2'b10;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (int'(addr) / 4)
      0: return 32'(m_sq);
      1: return 32'(m_cq);
      2: return 32'(cq_tail_in);
      3: return {m_err[0], 22'd0, 9'(pending_of(int'(cq_tail_in), m_cq))};
      4: return {30'd0, m_err[0], m_irq_en[0]};
      5: return ID;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle compare of the sideband outputs against the model.
  always @(posedge ACLK) begin
    tail_e = int'(cq_tail_in);
    rst_e  = ARESET;
    #1;
    exp_irq = rst_e ? 0 : ((p_irq_en != 0 && pending_of(tail_e, p_head) != 0) ? 1 : 0);
    if (mon_en) begin
      check("sq_tail_out", 32'(sq_tail_out), 32'(m_sq));
      check("cq_head_out", 32'(cq_head_out), 32'(m_cq));
      check("sq_tail_upd", 32'(sq_tail_upd), 32'(m_sq_upd));
      check("cq_head_upd", 32'(cq_head_upd), 32'(m_cq_upd));
      check("irq", 32'(irq), 32'(exp_irq));
    end
    p_irq_en = m_irq_en;
    p_head   = m_cq;
  end

  task automatic do_reset();
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    ARESET = 1;
    model_zero();
    @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready", 32'(S_AXI_WREADY), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 0);
    ARESET = 0;
    @(negedge ACLK);
    check("post_rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int gap, input int bhold, input logic [1:0] lit_resp);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    logic [1:0] mresp;
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWVALID = !aw_done;
      S_AXI_WVALID  = !w_done && (cyc >= gap);
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      cyc++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 0, 1);
      return;
    end
    model_write(addr, data, strb, mresp);
    @(negedge ACLK);
    m_sq_upd = 0; m_cq_upd = 0;
    check("bvalid", 32'(S_AXI_BVALID), 1);
    check("bresp_model", 32'(S_AXI_BRESP), 32'(mresp));
    check("bresp_lit", 32'(S_AXI_BRESP), 32'(lit_resp));
    for (int i = 0; i < bhold; i++) begin
      check("bhold_bvalid", 32'(S_AXI_BVALID), 1);
      check("bhold_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_BREADY = 0;
    check("bvalid_drop", 32'(S_AXI_BVALID), 0);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int rhold, input bit use_lit,
                          input logic [31:0] lit_data, input logic [1:0] lit_resp);
    int cyc;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; cyc = 0;
    while (!S_AXI_ARREADY && cyc < 40) begin
      @(negedge ACLK);
      cyc++;
    end
    if (!S_AXI_ARREADY) begin
      S_AXI_ARVALID = 0;
      check("rd_handshake_timeout", 0, 1);
      return;
    end
    exp_d = model_read(addr);
    exp_r = (int'(addr) / 4 > 5) ? 2'b10 : 2'b00;
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    check("rvalid", 32'(S_AXI_RVALID), 1);
    check("rdata_model", S_AXI_RDATA, exp_d);
    check("rresp_model", 32'(S_AXI_RRESP), 32'(exp_r));
    if (use_lit) begin
      check("rdata_lit", S_AXI_RDATA, lit_data);
      check("rresp_lit", 32'(S_AXI_RRESP), 32'(lit_resp));
    end
    for (int i = 0; i < rhold; i++) begin
      @(negedge ACLK);
      check("rhold_rvalid", 32'(S_AXI_RVALID), 1);
      check("rhold_rdata", S_AXI_RDATA, exp_d);
      check("rhold_arready", 32'(S_AXI_ARREADY), 0);
    end
    S_AXI_RREADY = 1;
    @(negedge ACLK);
    S_AXI_RREADY = 0;
    check("rvalid_drop", 32'(S_AXI_RVALID), 0);
  endtask

  initial begin
    ARESET = 1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    cq_tail_in = 0;
    model_zero();
    p_irq_en = 0; p_head = 0;
    repeat (2) @(negedge ACLK);
    do_reset();
    mon_en = 1;

    // ID register with a stalled R channel, then an unmapped read.
    axi_read(5'h14, 4, 1, ID, 2'b00);
    axi_read(5'h1C, 0, 1, 32'd0, 2'b10);

    // CQ head write with W trailing AW by three cycles.
    axi_write(5'h04, 32'd5, 4'hF, 3, 0, 2'b00);
    axi_read(5'h04, 0, 1, 32'd5, 2'b00);
    axi_write(5'h00, 32'd7, 4'hF, 0, 0, 2'b00);
    check("sq_tail_lit", 32'(sq_tail_out), 32'd7);

    // Error writes leave registers alone and set STATUS.err.
    axi_write(5'h00, 32'd16, 4'hF, 0, 0, 2'b10);
    axi_read(5'h0C, 0, 1, 32'h8000_000B, 2'b00);
    axi_write(5'h10, 32'h2, 4'hF, 1, 0, 2'b00);
    axi_read(5'h0C, 0, 1, 32'h0000_000B, 2'b00);
    axi_write(5'h00, 32'd3, 4'h7, 0, 0, 2'b10);
    axi_write(5'h08, 32'd3, 4'hF, 0, 0, 2'b10);
    axi_write(5'h18, 32'd3, 4'hF, 2, 0, 2'b10);
    axi_read(5'h00, 0, 1, 32'd7, 2'b00);
    axi_write(5'h10, 32'h2, 4'h0, 0, 0, 2'b00);
    axi_read(5'h10, 0, 1, 32'h2, 2'b00);
    axi_write(5'h10, 32'h2, 4'h1, 0, 0, 2'b00);
    axi_write(5'h00, 32'd7, 4'hF, 0, 0, 2'b00);
    axi_write(5'h00, 32'd15, 4'hF, 0, 0, 2'b00);

    // Wrapped pending count and interrupt.
    @(negedge ACLK);
    cq_tail_in = 4'd1;
    axi_write(5'h04, 32'd15, 4'hF, 0, 0, 2'b00);
    axi_write(5'h10, 32'h1, 4'hF, 0, 0, 2'b00);
    axi_read(5'h0C, 0, 1, 32'h0000_0002, 2'b00);
    check("irq_lit_high", 32'(irq), 1);
    axi_read(5'h10, 0, 1, 32'h1, 2'b00);
    axi_write(5'h04, 32'd1, 4'hF, 0, 0, 2'b00);
    repeat (2) @(negedge ACLK);
    check("irq_lit_low", 32'(irq), 0);

    // B channel stalled while a read proceeds alongside.
    fork
      axi_write(5'h00, 32'd9, 4'hF, 0, 5, 2'b00);
      begin
        repeat (3) @(negedge ACLK);
        axi_read(5'h08, 0, 1, 32'd1, 2'b00);
      end
    join

    // Reset between AW and W aborts the write.
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0;
    do_reset();
    repeat (3) begin
      check("abort_no_bvalid", 32'(S_AXI_BVALID), 0);
      @(negedge ACLK);
    end
    axi_write(5'h04, 32'd3, 4'hF, 0, 0, 2'b00);
    axi_read(5'h04, 0, 1, 32'd3, 2'b00);

    repeat (3) @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cq_doorbell_axil_slave.md
CQ_DOORBELL_AXIL_SLAVE -- requirements
Module: cq_doorbell_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 16, entries per queue (power of two, 2..256); QW = clog2(QUEUE_DEPTH).
REQ-004 SHALL have parameter ID_VALUE, default 32'h4351_0200, constant returned by ID register.
REQ-005 SHALL have one clock; reset is synchronous and active-high: ACLK input 1, rising-edge clock.
REQ-006 ARESET input 1, synchronous active-high reset.
REQ-007 S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-008 S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-009 S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-010 S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-011 S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-012 cq_tail_in in QW, current CQ tail from completion engine; cq_head_out out QW, last accepted CQ head doorbell; cq_head_upd out 1, one-cycle pulse on new head.
REQ-013 sq_tail_out out QW, last accepted SQ tail doorbell; sq_tail_upd out 1, one-cycle pulse; irq out 1, level interrupt.

Function
REQ-014 Register map (word offset): 0x00 SQ_TAIL RW, 0x04 CQ_HEAD RW, 0x08 CQ_TAIL RO (=cq_tail_in), 0x0C STATUS RO {[31] err, [8:0] pending}, 0x10 CTRL RW {[0] irq_en, [1] err W1C}, 0x14 ID RO; 0x18/0x1C unmapped.
REQ-015 AW and W SHALL be accepted independently: AWREADY high while no address latched and BVALID low; WREADY likewise for data; each latched on its VALID&READY.
REQ-016 Write SHALL commit in the cycle after both address and data are latched; BVALID asserts in that same cycle; BVALID holds until BREADY; new AW/W not accepted while BVALID high.
REQ-017 BRESP SHALL be OKAY(00) except SLVERR(10) for: write to RO/unmapped offset; doorbell write with WSTRB != 4'hF; doorbell value >= QUEUE_DEPTH (WDATA[31:QW] nonzero).
REQ-018 SLVERR writes SHALL leave all registers unchanged except setting STATUS.err.
REQ-019 Accepted SQ_TAIL/CQ_HEAD write SHALL update the output register and pulse the matching *_upd for exactly one cycle, the cycle after commit; rewriting an identical value still pulses.
REQ-020 CTRL write SHALL honour WSTRB[0] only; err bit written 1 clears STATUS.err; same-cycle new error sets it (set wins).
REQ-021 Read: ARREADY high while RVALID low; on AR handshake RVALID asserts next cycle with registered RDATA/RRESP; held stable until RREADY.
REQ-022 Unmapped read SHALL return RDATA 0, RRESP SLVERR; all mapped reads OKAY.
REQ-023 pending = (cq_tail_in - cq_head_out) mod QUEUE_DEPTH, zero-extended to 9 bits; wrap-around handled modulo, so tail 1, head 15 (depth 16) gives 2.
REQ-024 irq SHALL be registered: irq = irq_en & (pending != 0), one-cycle latency from cause.
REQ-025 Read and write to the same register in the same cycle: read returns pre-commit value.
REQ-026 At most one outstanding write and one outstanding read; read and write paths operate concurrently.

Reset
REQ-027 With ARESET high at a clock edge: all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, sq_tail_out/cq_head_out 0, *_upd 0, irq 0, irq_en 0, err 0, latched AW/W discarded.
REQ-028 Reset mid-transaction SHALL abort it without B/R response; first cycle after reset release AWREADY, WREADY, ARREADY all 1.

Verification
REQ-029 AW then W three cycles later, addr 0x04 data 5, strb F -> BVALID OKAY one cycle after W; cq_head_out=5, cq_head_upd one-cycle pulse.
REQ-030 Write 0x00 data 16 (depth 16) -> BRESP SLVERR, sq_tail_out unchanged, STATUS reads 0x8000_0000|pending; write CTRL 0x2 -> err cleared.
REQ-031 cq_tail_in=1, CQ_HEAD=15, CTRL=1 -> STATUS pending=2, irq=1; write CQ_HEAD=1 -> pending 0, irq 0 one cycle later.
REQ-032 Read 0x14 with RREADY held low 4 cycles -> RVALID/RDATA=ID_VALUE stable, ARREADY low until handshake; read 0x1C -> RDATA 0, SLVERR.
REQ-033 BREADY held low after write -> BVALID held, AWREADY/WREADY low; concurrent read of 0x08 completes normally.
REQ-034 ARESET asserted after AW accepted but before W -> no BVALID; post-reset write completes with OKAY and correct value.
